se_act_arbiter: RTL
===================

SE_ACT_ARBITER -- requirements
Module: se_act_arbiter

Interface
REQ-001 SHALL have parameter INT_BITS, default 16, integer bits of the Q-format data word.
REQ-002 SHALL have parameter FRAC_BITS, default 16, fractional bits; DATA_WIDTH = INT_BITS+FRAC_BITS.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the activation unit.
REQ-004 SHALL have parameter ACT_LAT, default 1, fixed cycles from act_enable to act_valid.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-008 req_data  in  NUM_REQ*DATA_WIDTH  packed signed operands; requester i at slice i.
REQ-009 req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on req_valid[i]&req_ready[i].
REQ-010 act_enable  out  1  issue strobe to the shared activation unit.
REQ-011 act_data_in  out  DATA_WIDTH  operand to the activation unit.
REQ-012 act_data_out  in  DATA_WIDTH  activation result.
REQ-013 act_valid  in  1  activation result valid.
REQ-014 act_overflow  in  1  activation saturation flag.
REQ-015 rsp_valid  out  1  response valid (single-cycle pulse).
REQ-016 rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the response.
REQ-017 rsp_data / rsp_overflow  out  DATA_WIDTH / 1  registered result and overflow flag.
REQ-018 ovf_count  out  16  saturating count of overflowed responses.
REQ-019 busy / err  out  1 / 1  operations in flight; sticky stray-result error.

Function
REQ-020 SHALL grant at most one requester per cycle, round-robin, searching upward from (last_granted+1) mod NUM_REQ.
REQ-021 req_ready SHALL be combinational from req_valid and the pointer; ready only for the selected valid requester; all zero when no requester is valid.
REQ-022 Pointer SHALL update to the granted index only on a transfer; idle cycles leave it unchanged.
REQ-023 On a transfer, act_enable SHALL be 1 and act_data_in SHALL equal the granted slice in that cycle; otherwise act_enable=0 and act_data_in=0.
REQ-024 SHALL track each issue in an ACT_LAT-deep tag pipeline (valid bit + id) advancing every cycle.
REQ-025 When act_valid=1 and the tag tail is valid, the next cycle SHALL produce rsp_valid=1, rsp_id=tail id, rsp_data=act_data_out, rsp_overflow=act_overflow; end-to-end latency = ACT_LAT+1 cycles.
REQ-026 act_valid=1 with an invalid tag tail SHALL set err (sticky until reset) and produce no response.
REQ-027 A valid tag tail without act_valid SHALL also set err and drop the tag.
REQ-028 ovf_count SHALL increment on each response with rsp_overflow=1 and hold at 16'hFFFF.
REQ-029 busy SHALL be 1 whenever any tag pipeline stage is valid.
REQ-030 SHALL sustain one issue per cycle back-to-back with no bubbles.

Reset
REQ-031 With rst=1 at a clk edge: pointer = NUM_REQ-1 (so index 0 has first priority), tags cleared, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_overflow=0, ovf_count=0, err=0.
REQ-032 While rst=1, req_ready=0 and act_enable=0; in-flight results returning after reset SHALL be discarded without setting err for ACT_LAT cycles after reset deassertion.

Structure
REQ-033 INT_BITS, FRAC_BITS, DATA_WIDTH defaults and the ID width function SHALL live in shared package se_pkg.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot grant, index).
REQ-035 The activation unit is external; this block SHALL contain no activation arithmetic.

Verification
REQ-036 Req0 only, data 32'h00028000, ReLU unit attached -> rsp_valid two cycles later, rsp_id=0, rsp_data=32'h00028000.
REQ-037 All four valid continuously -> grants 0,1,2,3,0,1 on consecutive cycles; responses carry ids in the same order.
REQ-038 Req2 data 32'hFFFF0000 -> rsp_id=2, rsp_data=32'h00000000, rsp_overflow=0.
REQ-039 Stub returning act_overflow=1 for 65540 issues -> ovf_count stops at 16'hFFFF.
REQ-040 rst asserted with two ops in flight -> next cycle rsp_valid=0, busy=0, first grant after release goes to req0, err stays 0.
REQ-041 Stub drives act_valid with nothing issued -> err=1 and held until rst.

Source files
------------

// File: rtl/se_pkg.sv
// Shared defaults and helpers for the activation arbiter slice.
// Q-format word geometry and index width calculation.
package se_pkg;

  localparam int SE_INT_BITS   = 16;
  localparam int SE_FRAC_BITS  = 16;
  localparam int SE_DATA_WIDTH = SE_INT_BITS + SE_FRAC_BITS;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester above ptr wins.
// Purely combinational; caller owns the pointer register.
import se_pkg::*;

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  // scan upward from ptr+1, wrapping, first hit wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/se_act_arbiter.sv
// Shares one external activation unit among NUM_REQ requesters.
// Tags each issue so results are routed back to their owner.
import se_pkg::*;

module se_act_arbiter #(
  parameter int INT_BITS  = SE_INT_BITS,
  parameter int FRAC_BITS = SE_FRAC_BITS,
  parameter int NUM_REQ   = 4,
  parameter int ACT_LAT   = 1,
  localparam int DATA_WIDTH = INT_BITS + FRAC_BITS,
  localparam int IW = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          act_enable,
  output logic [DATA_WIDTH-1:0]         act_data_in,
  input  logic [DATA_WIDTH-1:0]         act_data_out,
  input  logic                          act_valid,
  input  logic                          act_overflow,
  output logic                          rsp_valid,
  output logic [IW-1:0]                 rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_overflow,
  output logic [15:0]                   ovf_count,
  output logic                          busy,
  output logic                          err
);

  localparam int GW = $clog2(ACT_LAT + 1) + 1;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gidx;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;

  logic [ACT_LAT-1:0] tag_v;
  logic [IW-1:0]      tag_id [ACT_LAT];
  logic               tail_v;
  logic [IW-1:0]      tail_id;

  logic [GW-1:0]      gate_cnt;
  logic               gate_open;
  logic               fire;
  logic               stray;
  logic               lost;

  assign arb_req = rst ? '0 : req_valid;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  assign req_ready  = grant;
  assign xfer       = |(req_valid & grant);
  assign act_enable = xfer;

  // forward the granted operand, zero when idle
  always_comb begin
    act_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer && grant[i]) begin
        act_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign tail_v    = tag_v[ACT_LAT-1];
  assign tail_id   = tag_id[ACT_LAT-1];
  assign gate_open = (gate_cnt == '0);
  assign fire      = act_valid & tail_v;
  assign stray     = act_valid & ~tail_v & gate_open;
  assign lost      = tail_v & ~act_valid;
  assign busy      = |tag_v;

  // round-robin pointer moves only on a real transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(NUM_REQ - 1);
    end else if (xfer) begin
      ptr <= gidx;
    end
  end

  // tag pipeline mirrors the activation unit latency
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < ACT_LAT; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= xfer;
      tag_id[0] <= gidx;
      for (int i = 1; i < ACT_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // register the returning result with its owner id
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      rsp_valid <= fire;
      if (fire) begin
        rsp_id       <= tail_id;
        rsp_data     <= act_data_out;
        rsp_overflow <= act_overflow;
      end
    end
  end

  // saturating overflow counter, updated with the response
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (fire && act_overflow && ovf_count != 16'hFFFF) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

  // sticky error; results draining after reset are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      gate_cnt <= GW'(ACT_LAT);
    end else begin
      if (!gate_open) begin
        gate_cnt <= gate_cnt - GW'(1);
      end
      if (stray || lost) begin
        err <= 1'b1;
      end
    end
  end

endmodule
